ps2_host_tx: RTL

//  Host-to-device PS/2 transmitter. It sends one command byte to the keyboard/mouse, for

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_line_filter.sv | 46 ++++
 rtl/ps2_host_tx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, frame constants and
// the command bytes the host side issues.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SEND,
    ST_ACK_WAIT,
    ST_ACK_REL,
    ST_ABORT,
    ST_FIN
  } ps2_state_t;

  localparam int unsigned PS2_NBITS    = 10;
  localparam int unsigned PS2_ACK_FALL = 11;

  localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;

  // Bits shifted out after the start bit: data LSB first, odd parity, stop.
  function automatic logic [PS2_NBITS-1:0] ps2_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus low-level debounce for a PS/2 pad; emits a one-cycle
// strobe when a high line has read low for FILTER_CYCLES consecutive clocks.
module ps2_line_filter #(
  parameter int unsigned FILTER_CYCLES = 8
) (
  input  logic ck,
  input  logic reset,
  input  logic line_in,
  output logic line_sync,
  output logic fall
);

  localparam int unsigned LW = $clog2(FILTER_CYCLES + 1);

  logic          meta;
  logic          armed;
  logic [LW-1:0] low_cnt;

  // Re-arm only after a high sample so one long low yields a single strobe.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      meta      <= 1'b1;
      line_sync <= 1'b1;
      armed     <= 1'b0;
      low_cnt   <= '0;
      fall      <= 1'b0;
    end else begin
      meta      <= line_in;
      line_sync <= meta;
      fall      <= 1'b0;
      if (line_sync) begin
        low_cnt <= '0;
        armed   <= 1'b1;
      end else if (armed) begin
        if (low_cnt == LW'(FILTER_CYCLES - 1)) begin
          fall    <= 1'b1;
          armed   <= 1'b0;
          low_cnt <= '0;
        end else begin
          low_cnt <= low_cnt + LW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, ten device-clocked
// bits and ACK sampling, guarded by a watchdog between accepted clock falls.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned REQ_CYCLES     = 100,
  parameter int unsigned FILTER_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1500000
) (
  input  logic       ck,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err_timeout,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned MAX_A = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int unsigned MAX_P = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W = $clog2(MAX_P + 1);

  ps2_state_t           state;
  logic [CNT_W-1:0]     cnt;
  logic [PS2_NBITS-1:0] shreg;
  logic [3:0]           bitcnt;
  logic [3:0]           bitcnt_inc;
  logic                 ack_ok_reg;
  logic                 clk_sync;
  logic                 clk_fall;
  logic                 data_meta;
  logic                 data_sync;
  logic                 wd_expired;

  ps2_line_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_clk_filter (
    .ck       (ck),
    .reset    (reset),
    .line_in  (ps2_clk_in),
    .line_sync(clk_sync),
    .fall     (clk_fall)
  );

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      data_meta <= ps2_data_in;
      data_sync <= data_meta;
    end
  end

  assign wd_expired = !clk_fall && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bitcnt_inc = (bitcnt == 4'(PS2_ACK_FALL)) ? bitcnt : bitcnt + 4'd1;

  // One counter serves as phase timer in INHIBIT/REQ and as watchdog afterwards.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      shreg       <= '0;
      bitcnt      <= '0;
      ack_ok_reg  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ack_ok      <= 1'b0;
      err_timeout <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_INHIBIT;
            busy        <= 1'b1;
            ack_ok      <= 1'b0;
            err_timeout <= 1'b0;
            shreg       <= ps2_frame(tx_data);
            bitcnt      <= '0;
            cnt         <= '0;
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= 1'b0;
          end
        end
        ST_INHIBIT: begin
          if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
            state       <= ST_REQ;
            ps2_data_oe <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_REQ: begin
          if (cnt == CNT_W'(REQ_CYCLES - 1)) begin
            state      <= ST_SEND;
            ps2_clk_oe <= 1'b0;
            cnt        <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_SEND, ST_ACK_WAIT, ST_ACK_REL: begin
          if (wd_expired) begin
            state       <= ST_ABORT;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
          end else begin
            cnt <= clk_fall ? '0 : cnt + CNT_W'(1);
            if (state == ST_SEND) begin
              if (clk_fall) begin
                ps2_data_oe <= ~shreg[0];
                shreg       <= {1'b0, shreg[PS2_NBITS-1:1]};
                bitcnt      <= bitcnt_inc;
                if (bitcnt == 4'(PS2_NBITS - 1)) state <= ST_ACK_WAIT;
              end
            end else if (state == ST_ACK_WAIT) begin
              ps2_data_oe <= 1'b0;
              if (clk_fall) begin
                ack_ok_reg <= ~data_sync;
                bitcnt     <= bitcnt_inc;
                state      <= ST_ACK_REL;
              end
            end else if (clk_sync && data_sync) begin
              state       <= ST_FIN;
              done        <= 1'b1;
              ack_ok      <= ack_ok_reg;
              err_timeout <= 1'b0;
            end
          end
        end
        ST_ABORT: begin
          state       <= ST_FIN;
          done        <= 1'b1;
          ack_ok      <= 1'b0;
          err_timeout <= 1'b1;
        end
        ST_FIN: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
